// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD write arbiter and its byte FIFO.
package lcd_sched_pkg;
  localparam int LCD_DATA_W = 8;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    WAIT_ACK,
    WAIT_DONE,
    RST_PULSE
  } state_t;
endpackage

// File: rtl/lcd_byte_fifo.sv
// Synchronous byte FIFO with flush; level counts occupied entries (0..DEPTH).
module lcd_byte_fifo
  import lcd_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic [LCD_DATA_W-1:0]     push_data,
  input  logic                      pop,
  output logic [LCD_DATA_W-1:0]     pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [LCD_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/lcd_write_arbiter.sv
// Message-granular two-port arbiter feeding a byte FIFO, plus the issue FSM
// that strobes each byte onto the LCD controller bus with busy handshake.
module lcd_write_arbiter
  import lcd_sched_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int E_HOLD_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 1024,
  parameter int RST_CYCLES    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0_valid,
  input  logic [LCD_DATA_W-1:0]         req0_data,
  input  logic                          req0_last,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [LCD_DATA_W-1:0]         req1_data,
  input  logic                          req1_last,
  output logic                          req1_ready,
  input  logic                          lcd_reinit,
  output logic                          lcd_e,
  output logic [LCD_DATA_W-1:0]         lcd_data,
  output logic                          lcd_rst,
  input  logic                          lcd_can_write,
  output logic                          busy,
  output logic                          timeout_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int MAX_HR  = (E_HOLD_CYCLES > RST_CYCLES) ? E_HOLD_CYCLES : RST_CYCLES;
  localparam int CNT_MAX = (ACK_TIMEOUT > MAX_HR) ? ACK_TIMEOUT : MAX_HR;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  grant_valid;
  logic                  grant_port;
  logic                  tie_prio;
  logic                  reinit_pending;
  logic                  acc0, acc1;
  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic                  push_last;
  logic [LCD_DATA_W-1:0] push_data, fifo_rd_data;
  logic                  cnt_expired;

  assign req0_ready = grant_valid && (grant_port == PORT_CPU) && !fifo_full;
  assign req1_ready = grant_valid && (grant_port == PORT_DBG) && !fifo_full;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign fifo_push  = acc0 || acc1;
  assign push_data  = acc1 ? req1_data : req0_data;
  assign push_last  = acc1 ? req1_last : req0_last;

  assign cnt_expired = (cnt == CW'(ACK_TIMEOUT - 1));
  // Every entry into RST_PULSE discards queued bytes and any held grant.
  assign fifo_flush  = ((state == IDLE) && reinit_pending) ||
                       ((state == WAIT_DONE) && !lcd_can_write && cnt_expired);
  assign fifo_pop    = (state == IDLE) && !reinit_pending && !fifo_empty && lcd_can_write;
  assign busy        = (state != IDLE) || !fifo_empty;

  lcd_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Grant is held for a whole message; tie_prio only moves when a tie is resolved.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_valid <= 1'b0;
      grant_port  <= PORT_CPU;
      tie_prio    <= PORT_CPU;
    end else if (fifo_flush) begin
      grant_valid <= 1'b0;
    end else if (grant_valid) begin
      if (fifo_push && push_last) grant_valid <= 1'b0;
    end else if (!fifo_full && (req0_valid || req1_valid)) begin
      grant_valid <= 1'b1;
      if (req0_valid && req1_valid) begin
        grant_port <= tie_prio;
        tie_prio   <= ~tie_prio;
      end else begin
        grant_port <= req1_valid ? PORT_DBG : PORT_CPU;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RST_PULSE;
      cnt            <= '0;
      lcd_e          <= 1'b0;
      lcd_data       <= '0;
      lcd_rst        <= 1'b1;
      timeout_flag   <= 1'b0;
      reinit_pending <= 1'b0;
    end else begin
      if (cnt != CW'(CNT_MAX)) cnt <= cnt + 1'b1;
      if (lcd_reinit)      reinit_pending <= 1'b1;
      else if (fifo_flush) reinit_pending <= 1'b0;

      case (state)
        IDLE: begin
          if (reinit_pending) begin
            state   <= RST_PULSE;
            lcd_rst <= 1'b1;
            cnt     <= '0;
          end else if (fifo_pop) begin
            state    <= STROBE;
            lcd_e    <= 1'b1;
            lcd_data <= fifo_rd_data;
            cnt      <= '0;
          end
        end
        STROBE: begin
          if (cnt == CW'(E_HOLD_CYCLES - 1)) begin
            lcd_e <= 1'b0;
            state <= WAIT_ACK;
            cnt   <= '0;
          end
        end
        WAIT_ACK: begin
          if (!lcd_can_write) begin
            state <= WAIT_DONE;
            cnt   <= '0;
          end else if (cnt_expired) begin
            timeout_flag <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
          end
        end
        WAIT_DONE: begin
          if (lcd_can_write) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_expired) begin
            timeout_flag <= 1'b1;
            state        <= RST_PULSE;
            lcd_rst      <= 1'b1;
            cnt          <= '0;
          end
        end
        RST_PULSE: begin
          // Pulse phase first, then wait for the controller to come ready.
          if (lcd_rst) begin
            if (cnt == CW'(RST_CYCLES - 1)) lcd_rst <= 1'b0;
          end else if (lcd_can_write) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_expired) begin
            timeout_flag <= 1'b1;
            state        <= IDLE;
            cnt          <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed/randomized bench for lcd_write_arbiter with a queue-level byte-order model.
module tb_lcd_write_arbiter;
  localparam int FIFO_DEPTH = 8;
  localparam int E_HOLD     = 2;
  localparam int ACK_TO     = 1024;
  localparam int RST_CYC    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_last, req1_valid, req1_last;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       lcd_reinit;
  logic       lcd_e, lcd_rst, lcd_can_write;
  logic [7:0] lcd_data;
  logic       busy, timeout_flag;
  logic [3:0] fifo_level;

  always #5 clk = ~clk;

  lcd_write_arbiter #(
    .FIFO_DEPTH(FIFO_DEPTH), .E_HOLD_CYCLES(E_HOLD),
    .ACK_TIMEOUT(ACK_TO), .RST_CYCLES(RST_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .lcd_reinit(lcd_reinit), .lcd_e(lcd_e), .lcd_data(lcd_data), .lcd_rst(lcd_rst),
    .lcd_can_write(lcd_can_write), .busy(busy), .timeout_flag(timeout_flag),
    .fifo_level(fifo_level)
  );

  int         total = 0;
  int         bad = 0;
  int         ctl_mode = 2;   // 0: drop 3 after strobe for 10; 1: held low; 2: never drops
  int         tie_next = 0;   // port that the model expects to win the next tie
  logic [7:0] got_data[$];
  int         got_len[$];
  bit         got_stable[$];
  logic [7:0] exp_q[$];
  logic [7:0] msg0[$];
  logic [7:0] msg1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [7:0] d, input logic l);
    if (p == 0) begin req0_valid = v; req0_data = d; req0_last = l; end
    else begin req1_valid = v; req1_data = d; req1_last = l; end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic send(input int p, input logic [7:0] m[$], input bit with_last);
    for (int i = 0; i < m.size(); i++) begin
      int k = 0;
      drive(p, 1'b1, m[i], with_last && (i == m.size() - 1));
      while (!rdy(p) && k < 300) begin @(negedge clk); k++; end
      if (!rdy(p)) begin
        chk($sformatf("ready_p%0d_byte%0d", p, i), 32'(rdy(p)), 32'd1);
        break;
      end
      @(negedge clk);
    end
    drive(p, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic push_exp(input logic [7:0] m[$]);
    foreach (m[i]) exp_q.push_back(m[i]);
  endtask

  task automatic check_stream(input string tag, input int budget);
    int k = 0;
    while (got_data.size() < exp_q.size() && k < budget) begin @(negedge clk); k++; end
    k = 0;
    while (busy && k < 400) begin @(negedge clk); k++; end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(got_data.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_data.size() > 0) begin
      chk({tag, "_data"}, 32'(got_data.pop_front()), 32'(exp_q.pop_front()));
      chk({tag, "_ehold"}, 32'(got_len.pop_front()), 32'(E_HOLD));
      chk({tag, "_stable"}, 32'(got_stable.pop_front()), 32'd1);
    end
    got_data.delete(); got_len.delete(); got_stable.delete(); exp_q.delete();
  endtask

  // Strobe monitor: records each lcd_e pulse (byte, width, data stability).
  initial begin
    int len = 0;
    logic [7:0] d = 8'h00;
    bit st = 1'b1;
    forever begin
      @(negedge clk);
      if (lcd_e === 1'b1) begin
        if (len == 0) begin d = lcd_data; st = 1'b1; end
        else if (lcd_data !== d) st = 1'b0;
        len++;
      end else if (len != 0) begin
        got_data.push_back(d); got_len.push_back(len); got_stable.push_back(st);
        len = 0;
      end
    end
  end

  // Controller model for canWriteAgain.
  initial begin
    int t = 0;
    logic ep = 1'b0;
    lcd_can_write = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (ctl_mode == 1) begin lcd_can_write = 1'b0; t = 0; end
      else if (ctl_mode == 2) begin lcd_can_write = 1'b1; t = 0; end
      else begin
        if (lcd_e && !ep) t = 1;
        else if (t != 0) t++;
        lcd_can_write = (t >= 3 && t < 13) ? 1'b0 : 1'b1;
        if (t >= 13) t = 0;
      end
      ep = lcd_e;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    reset = 1'b1; lcd_reinit = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_lcd_e", 32'(lcd_e), 32'd0);
    chk("rst_lcd_data", 32'(lcd_data), 32'd0);
    chk("rst_lcd_rst", 32'(lcd_rst), 32'd1);
    chk("rst_timeout", 32'(timeout_flag), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready0", 32'(req0_ready), 32'd0);

    // Power-on reinitialisation
    reset = 1'b0;
    n = 0;
    while (lcd_rst && n < 50) begin n++; @(negedge clk); end
    chk("por_rst_cycles", 32'(n), 32'(RST_CYC));
    chk("por_busy_pulse_end", 32'(busy), 32'd1);
    @(negedge clk);
    chk("por_busy_idle", 32'(busy), 32'd0);
    chk("por_no_strobe", 32'(got_data.size()), 32'd0);

    // Single write
    ctl_mode = 0;
    msg0 = {8'h41};
    push_exp(msg0);
    send(0, msg0, 1'b1);
    k = 0;
    while (lcd_can_write && k < 100) begin @(negedge clk); k++; end
    chk("single_cw_drop", 32'(lcd_can_write), 32'd0);
    k = 0;
    while (!lcd_can_write && k < 100) begin @(negedge clk); k++; end
    chk("single_idle_after_rise", 32'(busy), 32'd0);
    check_stream("single", 500);

    // Contention: first tie to port 0, message order kept intact
    msg0 = {8'h48, 8'h49};
    msg1 = {8'h4F, 8'h4B};
    if (tie_next == 0) begin push_exp(msg0); push_exp(msg1); end
    else begin push_exp(msg1); push_exp(msg0); end
    tie_next ^= 1;
    fork
      send(0, msg0, 1'b1);
      send(1, msg1, 1'b1);
    join
    check_stream("contend", 1000);

    // Second tie: random bytes, must go to the other port
    msg0 = {8'($urandom), 8'($urandom)};
    msg1 = {8'($urandom)};
    if (tie_next == 0) begin push_exp(msg0); push_exp(msg1); end
    else begin push_exp(msg1); push_exp(msg0); end
    tie_next ^= 1;
    fork
      send(0, msg0, 1'b1);
      send(1, msg1, 1'b1);
    join
    check_stream("tie2", 1000);

    // Backpressure: controller busy, fill the FIFO from port 1
    ctl_mode = 1;
    @(negedge clk);
    msg1.delete();
    for (int i = 0; i < FIFO_DEPTH; i++) msg1.push_back(8'($urandom));
    push_exp(msg1);
    send(1, msg1, 1'b0);
    chk("bp_level_full", 32'(fifo_level), 32'(FIFO_DEPTH));
    chk("bp_ready_low", 32'(req1_ready), 32'd0);
    chk("bp_no_strobe", 32'(got_data.size()), 32'd0);
    ctl_mode = 0;
    msg1 = {8'($urandom)};
    push_exp(msg1);
    send(1, msg1, 1'b1);
    check_stream("bp", 3000);

    // Ack timeout: controller never drops canWriteAgain
    ctl_mode = 2;
    chk("tmo_flag_before", 32'(timeout_flag), 32'd0);
    msg0 = {8'($urandom), 8'($urandom)};
    push_exp(msg0);
    send(0, msg0, 1'b1);
    k = 0;
    while (!lcd_e && k < 100) begin @(negedge clk); k++; end
    while (lcd_e && k < 200) begin @(negedge clk); k++; end
    n = 0;
    while (!timeout_flag && n < ACK_TO + 100) begin @(negedge clk); n++; end
    chk("tmo_cycles", 32'(n), 32'(ACK_TO));
    ctl_mode = 0;
    check_stream("tmo", 1000);
    chk("tmo_flag_sticky", 32'(timeout_flag), 32'd1);

    // Reinit while 5 bytes queued and one byte in WAIT_DONE
    msg0.delete();
    for (int i = 0; i < 6; i++) msg0.push_back(8'($urandom));
    exp_q.push_back(msg0[0]);
    send(0, msg0, 1'b0);
    k = 0;
    while (lcd_can_write && k < 100) begin @(negedge clk); k++; end
    chk("ri_in_wait_done", 32'(lcd_can_write), 32'd0);
    chk("ri_level_before", 32'(fifo_level), 32'd5);
    lcd_reinit = 1'b1;
    @(negedge clk);
    lcd_reinit = 1'b0;
    k = 0;
    while (!lcd_rst && k < 200) begin @(negedge clk); k++; end
    chk("ri_inflight_done", 32'(got_data.size()), 32'd1);
    chk("ri_level_flushed", 32'(fifo_level), 32'd0);
    n = 0;
    while (lcd_rst && n < 50) begin n++; @(negedge clk); end
    chk("ri_rst_cycles", 32'(n), 32'(RST_CYC));
    chk("ri_ready0_dropped", 32'(req0_ready), 32'd0);
    msg1 = {8'($urandom)};
    push_exp(msg1);
    send(1, msg1, 1'b1);
    check_stream("reinit", 1000);
    chk("ri_level_end", 32'(fifo_level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
